iq_snap_capture_ctrl: RTL and testbench
=======================================

IQ_SNAP_CAPTURE_CTRL -- requirements
Module: iq_snap_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning BRAM port-A address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning sample/BRAM word width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port arm  input  1  single-cycle request to arm a capture.
REQ-006 SHALL have port abort  input  1  single-cycle request to cancel arm/capture.
REQ-007 SHALL have port trig  input  1  capture trigger, level, sampled in ARMED only.
REQ-008 SHALL have port len  input  ADDR_W  last address to write (word count = len+1), latched on accepted arm.
REQ-009 SHALL have port din_valid  input  1  qualifies din.
REQ-010 SHALL have port din  input  DATA_W  IQ-average sample.
REQ-011 SHALL have port bram_we  output  1  port-A write enable.
REQ-012 SHALL have port bram_en_a  output  1  port-A enable.
REQ-013 SHALL have port bram_addr  output  ADDR_W  port-A address.
REQ-014 SHALL have port bram_wr_data  output  DATA_W  port-A write data.
REQ-015 SHALL have ports busy, done  output  1 each  status: ARMED/CAPTURE, and capture complete (sticky).
REQ-016 SHALL have port wr_count  output  ADDR_W+1  words written in current/last capture.

Function
REQ-017 SHALL implement FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-018 IDLE or DONE, arm=1 -> ARMED next cycle; len latched; done cleared; wr_count cleared.
REQ-019 ARMED, trig=1 -> CAPTURE next cycle; trig in the same cycle as arm SHALL NOT count.
REQ-020 CAPTURE: each cycle with din_valid=1 SHALL produce one write, din registered once: bram_we=bram_en_a=1, bram_wr_data=din, exactly 1 cycle after the din_valid cycle.
REQ-021 Write address SHALL start at 0 and increment by 1 per write; no gaps for din_valid=0 cycles.
REQ-022 Write at address == latched len SHALL be the last; FSM -> DONE the cycle that write is issued; further din_valid ignored.
REQ-023 Address SHALL never wrap; len = 2^ADDR_W-1 writes the full memory then stops.
REQ-024 DONE: done=1 sticky until next accepted arm or reset; busy=0.
REQ-025 arm in ARMED or CAPTURE SHALL be ignored (no relatch, no restart).
REQ-026 abort in ARMED or CAPTURE -> IDLE next cycle; done stays 0; wr_count holds words already written; any write for a sample accepted before abort SHALL still complete.
REQ-027 abort and arm in the same cycle: abort wins when busy; arm wins in IDLE/DONE.
REQ-028 bram_we, bram_en_a SHALL be 0 in every cycle with no write; bram_addr holds last value.
REQ-029 wr_count SHALL increment on each issued write (range 0..2^ADDR_W).

Reset
REQ-030 rst_n=0 SHALL force state IDLE, bram_we=0, bram_en_a=0, bram_addr=0, bram_wr_data=0, busy=0, done=0, wr_count=0, latched len=0, asynchronously.
REQ-031 Reset mid-capture SHALL abandon capture; no write issued after rst_n deasserts until a new arm/trig.

Structure
REQ-032 State encoding enum and ADDR_W/DATA_W defaults SHALL live in shared package snap_ctrl_pkg.
REQ-033 Single flat module; no sub-modules; BRAM instantiated outside and driven by port-A outputs.

Verification
REQ-034 len=3, arm, trig after 5 cycles, din_valid continuous din=0xA0..0xA5 -> writes 0xA0..0xA3 at addr 0..3, done=1, wr_count=4, 0xA4 not written.
REQ-035 len=2, din_valid toggling 1,0,1,0,1 -> 3 writes at addr 0,1,2 each 1 cycle after its valid, bram_we=0 on gap cycles.
REQ-036 arm+trig same cycle, then trig low -> stays ARMED, no writes; later trig -> capture starts.
REQ-037 len=1023, continuous valid -> 1024 writes, last addr 1023, no wrap, wr_count=1024.
REQ-038 abort after 2 writes of len=7 -> IDLE, done=0, wr_count=2; rst_n pulse mid-capture -> all outputs zero immediately.

Source files
------------

// File: rtl/snap_ctrl_pkg.sv
// Shared definitions for the IQ snapshot capture controller:
// default widths and the controller state encoding.
package snap_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/iq_snap_capture_ctrl_if.sv
// BRAM port-A write bundle between the capture controller (master)
// and the externally instantiated block RAM (slave).
interface iq_snap_capture_ctrl_if #(
  parameter int ADDR_W = snap_ctrl_pkg::ADDR_W_DEF,
  parameter int DATA_W = snap_ctrl_pkg::DATA_W_DEF
);

  logic              bram_we;
  logic              bram_en_a;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wr_data;

  modport master (
    output bram_we,
    output bram_en_a,
    output bram_addr,
    output bram_wr_data
  );

  modport slave (
    input bram_we,
    input bram_en_a,
    input bram_addr,
    input bram_wr_data
  );

endinterface

// File: rtl/iq_snap_capture_ctrl.sv
// Arm/trigger snapshot controller: after arm and trigger, streams valid
// IQ samples into BRAM addresses 0..len, one registered write per sample.
module iq_snap_capture_ctrl
  import snap_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig,
  input  logic [ADDR_W-1:0]      len,
  input  logic                   din_valid,
  input  logic [DATA_W-1:0]      din,
  iq_snap_capture_ctrl_if.master bram,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W:0]        wr_count
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e              r_state;
  state_e              w_next_state;
  logic                w_arm_accept;
  logic                w_wr_fire;
  logic                w_last;

  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W:0]     r_wr_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wr_data;

  // The word count doubles as the next write address; the write that
  // lands on the latched len is the final one.
  assign w_last = (r_wr_count == {1'b0, r_len});

  // NOTE: every combinational output gets a default before the case so
  // that no path leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_arm_accept = 1'b0;
    w_wr_fire    = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          w_next_state = ST_ARMED;
          w_arm_accept = 1'b1;
        end
      end
      ST_ARMED: begin
        if (abort)     w_next_state = ST_IDLE;
        else if (trig) w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (din_valid) begin
          w_wr_fire = 1'b1;
          if (w_last) w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_wr_count <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
    end else begin
      r_we <= w_wr_fire;
      if (w_arm_accept) begin
        r_len      <= len;
        r_wr_count <= '0;
      end
      // Address and data hold their last value between writes.
      if (w_wr_fire) begin
        r_addr     <= r_wr_count[ADDR_W-1:0];
        r_wr_data  <= din;
        r_wr_count <= r_wr_count + CNT_ONE;
      end
    end
  end

  assign bram.bram_we      = r_we;
  assign bram.bram_en_a    = r_we;
  assign bram.bram_addr    = r_addr;
  assign bram.bram_wr_data = r_wr_data;

  assign busy     = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign done     = (r_state == ST_DONE);
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_iq_snap_capture_ctrl.sv
// Self-checking bench for iq_snap_capture_ctrl: directed capture scenarios
// plus randomized control traffic compared against a behavioural model.
module tb_iq_snap_capture_ctrl;
  import snap_ctrl_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, abort, trig, din_valid;
  logic [AW-1:0] len;
  logic [DW-1:0] din;
  logic          busy, done;
  logic [AW:0]   wr_count;

  iq_snap_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bram_if ();

  iq_snap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .abort     (abort),
    .trig      (trig),
    .len       (len),
    .din_valid (din_valid),
    .din       (din),
    .bram      (bram_if),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: "armed", "capturing" and "done" flags, the number of
  // words stored so far, and the last write seen on the BRAM port.
  bit            m_armed, m_cap, m_done, m_we;
  int            m_len, m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // Memory image rebuilt from the observed BRAM port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            n_writes;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_cap = 0; m_done = 0; m_we = 0;
    m_len = 0; m_cnt = 0; m_addr = '0; m_data = '0;
  endtask

  // One clock of behaviour: word k of a capture goes to address k, and the
  // capture ends once len+1 words are stored.
  task automatic model_clock(input bit a, input bit ab, input bit t, input bit dv,
                             input logic [AW-1:0] l, input logic [DW-1:0] d);
    m_we = 0;
    if (!m_armed && !m_cap) begin
      if (a) begin
        m_armed = 1; m_done = 0; m_len = int'(l); m_cnt = 0;
      end
    end else if (ab) begin
      m_armed = 0; m_cap = 0;
    end else if (m_armed) begin
      if (t) begin
        m_armed = 0; m_cap = 1;
      end
    end else if (dv) begin
      m_we   = 1;
      m_addr = AW'(m_cnt);
      m_data = d;
      m_cnt++;
      if (m_cnt == m_len + 1) begin
        m_cap = 0; m_done = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("bram_we",      bram_if.bram_we,      m_we);
    check("bram_en_a",    bram_if.bram_en_a,    m_we);
    check("bram_addr",    bram_if.bram_addr,    m_addr);
    check("bram_wr_data", bram_if.bram_wr_data, m_data);
    check("busy",         busy,                 m_armed | m_cap);
    check("done",         done,                 m_done);
    check("wr_count",     wr_count,             m_cnt);
  endtask

  task automatic step(input bit a, input bit ab, input bit t, input bit dv,
                      input logic [AW-1:0] l, input logic [DW-1:0] d);
    @(negedge clk);
    arm = a; abort = ab; trig = t; din_valid = dv; len = l; din = d;
    @(posedge clk);
    model_clock(a, ab, t, dv, l, d);
    #1;
    compare_all();
    if (bram_if.bram_we === 1'b1) begin
      mem[bram_if.bram_addr] = bram_if.bram_wr_data;
      n_writes++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    n_writes = 0;
  endtask

  initial begin
    rst_n = 1'b0; arm = 0; abort = 0; trig = 0; din_valid = 0; len = '0; din = '0;
    clear_mem();
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // len=3, trigger after 5 armed cycles, continuous samples 0xA0..0xA5.
    clear_mem();
    step(1, 0, 0, 0, 10'd3, '0);
    idle(5);
    step(0, 0, 1, 0, '0, '0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, '0, DW'(32'hA0 + i));
    idle(2);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_count", wr_count, 4);
    check("t1_writes", n_writes, 4);
    for (int i = 0; i < 4; i++) check("t1_mem", mem[i], 32'hA0 + i);
    check("t1_no_a4", mem[4], 0);

    // len=2 with gapped valid 1,0,1,0,1.
    clear_mem();
    step(1, 0, 0, 0, 10'd2, '0);
    step(0, 0, 1, 0, '0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, (i % 2) == 0, '0, DW'(32'hB0 + i));
    idle(1);
    check("t2_writes", n_writes, 3);
    check("t2_mem0", mem[0], 32'hB0);
    check("t2_mem1", mem[1], 32'hB2);
    check("t2_mem2", mem[2], 32'hB4);
    check("t2_done", done, 1);

    // arm and trig together: trig is not counted, controller stays armed.
    clear_mem();
    step(1, 0, 1, 1, 10'd5, 32'h11);
    idle(3);
    check("t3_armed_busy", busy, 1);
    check("t3_no_writes", n_writes, 0);
    step(0, 0, 1, 0, '0, '0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, '0, DW'(32'hC0 + i));
    check("t3_done", done, 1);
    check("t3_count", wr_count, 6);

    // len=7: arm during capture is ignored, abort after 2 writes.
    clear_mem();
    step(1, 0, 0, 0, 10'd7, '0);
    step(0, 0, 1, 0, '0, '0);
    step(0, 0, 0, 1, '0, 32'hD0);
    step(1, 0, 0, 1, 10'd0, 32'hD1);
    step(0, 1, 0, 0, '0, '0);
    idle(2);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_count", wr_count, 2);
    check("t4_writes", n_writes, 2);

    // Full memory: len=1023 with continuous samples, no wrap.
    clear_mem();
    step(1, 0, 0, 0, 10'd1023, '0);
    step(0, 0, 1, 0, '0, '0);
    for (int i = 0; i < 1028; i++) step(0, 0, 0, 1, '0, DW'(i));
    check("t5_count", wr_count, 1024);
    check("t5_done", done, 1);
    check("t5_last_addr", bram_if.bram_addr, 1023);
    check("t5_writes", n_writes, 1024);
    check("t5_mem_last", mem[1023], 1023);

    // Asynchronous reset in the middle of a capture.
    clear_mem();
    step(1, 0, 0, 0, 10'd20, '0);
    step(0, 0, 1, 0, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, '0, DW'(32'hE0 + i));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_we", bram_if.bram_we, 0);
    check("rst_en_a", bram_if.bram_en_a, 0);
    check("rst_addr", bram_if.bram_addr, 0);
    check("rst_data", bram_if.bram_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_writes = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, '0, DW'(32'hF0 + i));
    check("rst_no_writes", n_writes, 0);

    // Randomized control traffic.
    for (int i = 0; i < 4000; i++) begin
      bit            a, ab, t, dv;
      logic [AW-1:0] l;
      a  = ($urandom_range(0, 19) == 0);
      ab = ($urandom_range(0, 39) == 0);
      t  = ($urandom_range(0, 7) == 0);
      dv = ($urandom_range(0, 1) == 1) && !ab;
      l  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      step(a, ab, t, dv, l, DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
